icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped instruction cache; the responder end of the Fetcher's addr/rn → Inst/Read_ready read interface.
- Serves hits with one-cycle latency.
- Refills missed lines word-by-word from the memory controller.
- Honours the flow-controller clr to discard stale responses.

Parameters:
- LINES, 16, number of cache lines (power of two)
- LINE_WORDS, 4, 32-bit words per line (power of two)
- ADDR_USED, 18, low address bits used; addr[31:ADDR_USED] ignored

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-high
- rdy  input  1  global ready; low freezes all state and outputs
- addr  input  32  fetch address from Fetcher, word aligned
- rn  input  1  read enable from Fetcher (held high while a fetch is wanted)
- clr  input  1  flow-controller redirect; cancels any response in flight
- Inst  output  32  returned instruction, valid when Read_ready=1
- Read_ready  output  1  one-cycle pulse, Inst valid
- mem_req  output  1  word read request to memory controller
- mem_addr  output  32  word address of refill beat
- mem_data  input  32  refill data
- mem_valid  input  1  mem_data valid this cycle; one pulse per requested word

Behaviour:
- Address split (defaults): offset = addr[3:2], index = addr[7:4], tag = addr[17:8]. Widths derive from parameters.
- Reset (asynchronous):
  - All valid bits cleared; state IDLE.
  - Read_ready=0, Inst=0, mem_req=0, mem_addr=0, word counter=0.
  - Tag and data arrays are not reset.
- rdy=0: no register changes, including array writes. A mem_valid beat arriving while rdy=0 is not captured. The memory controller shares rdy, so no beats are presented then.
- Read_ready is a registered output and pulses for exactly one cycle per accepted request.
- Request acceptance: at a posedge with state=IDLE, rn=1, clr=0 and Read_ready=0.
  - The Read_ready=0 condition masks the edge at which the Fetcher is still updating addr.
  - The request address is latched into req_addr.
- States:
  - IDLE, request accepted, hit (valid[index] and tag match): next cycle Read_ready=1, Inst=data[index][offset]. Stay IDLE. Latency 1 cycle.
  - IDLE, request accepted, miss: go to REFILL.
    - mem_req=1; mem_addr = line base of req_addr; counter=0.
    - valid[index] cleared immediately (the victim line is overwritten).
  - REFILL: mem_req and mem_addr held until mem_valid.
    - Each mem_valid beat writes data[index][counter] and increments counter.
    - mem_addr advances by 4 on the same edge.
    - On the last beat (counter=LINE_WORDS-1): write tag, set valid, mem_req=0, go to RESPOND.
    - rn/addr changes during REFILL are ignored.
  - RESPOND: next edge Read_ready=1, Inst=data[index][offset] of req_addr; go to IDLE.
- clr handling:
  - clr=1 in IDLE: no request accepted; a Read_ready that would be set at that edge is forced to 0.
  - clr=1 during REFILL: refill runs to completion (line becomes valid) but the response is cancelled. A sticky cancel flag is set; RESPOND then returns to IDLE with Read_ready=0.
  - clr=1 in RESPOND: Read_ready stays 0. The cancel flag clears on IDLE entry.
- clr and a new rn on the same cycle: clr wins. The request with the target address is accepted on the following edge.
- Index wrap: the line base is computed by clearing the offset bits. mem_addr increments stay within the line; no carry into the index.
- Reset mid-refill: the line is invalid and mem_req drops immediately. Late mem_valid beats after reset are ignored because the state is IDLE.

Decomposition:
- Shared package (constants.v):
  - Data_Bus width, True/False macros.
  - ICache state encodings (IDLE/REFILL/RESPOND).
  - Default LINES/LINE_WORDS.
- One natural sub-module: icache_array. It holds the tag/valid/data storage, with a combinational read port (index, offset → tag, valid, word) and a synchronous write port (word write, tag+valid write, valid clear, async valid reset).
- The FSM stays in icache.

Test Plan:
- Cold miss:
  - Stimulus: rn=1, addr=0x100; memory returns 0xA0,0xA1,0xA2,0xA3 with 2-cycle gaps.
  - Response: mem_addr steps 0x100,0x104,0x108,0x10C; one Read_ready pulse with Inst=0xA0 one cycle after the last beat.
- Hit:
  - Stimulus: after the cold miss, addr=0x108.
  - Response: Read_ready=1, Inst=0xA2 exactly one cycle after acceptance; mem_req stays 0.
- Conflict:
  - Stimulus: addr=0x1100 (same index, new tag), then 0x100.
  - Response: both miss, both refill, mem_addr bases are 0x1100 then 0x100.
- clr mid-refill:
  - Stimulus: clr pulse after the second beat of a 0x200 miss.
  - Response: no Read_ready for 0x200. A later request to 0x204 hits with 1-cycle latency.
- rdy stall:
  - Stimulus: rdy=0 for 3 cycles spanning a hit response.
  - Response: Read_ready held, not duplicated; exactly one pulse total.
- Async reset:
  - Stimulus: assert rst between posedges during REFILL.
  - Response: mem_req=0 and Read_ready=0 immediately. A following request to the same address misses.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared constants, state encodings and address helpers for the instruction cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: data bus width, boolean constants, default geometry, FSM state
// encodings and a line-base helper used when starting a refill.
package icache_pkg;

   localparam int   DATA_W = 32;
   localparam logic TRUE   = 1'b1;
   localparam logic FALSE  = 1'b0;

   localparam int DEF_LINES      = 16;
   localparam int DEF_LINE_WORDS = 4;
   localparam int DEF_ADDR_USED  = 18;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REFILL  = 2'd1,
      ST_RESPOND = 2'd2
   } state_t;

   // Clears the word-offset and byte bits, giving the first word address of the line.
   function automatic logic [DATA_W-1:0] line_base(input logic [DATA_W-1:0] a,
                                                    input int line_words);
      return a & ~(DATA_W'(line_words * 4 - 1));
   endfunction

endpackage

// File: rtl/icache_if.sv
// Fetch-side and memory-side signal bundle of the instruction cache.
// Latency: n/a (wiring only).
// Backpressure: none on the fetch side; refill beats are paced by mem_valid.
//
// slave  : cache view  (addr/rn/clr/mem_data/mem_valid in, Inst/Read_ready/mem_req/mem_addr out)
// master : Fetcher + memory controller view (directions reversed)
interface icache_if;
   import icache_pkg::*;

   logic [DATA_W-1:0] addr;
   logic              rn;
   logic              clr;
   logic [DATA_W-1:0] Inst;
   logic              Read_ready;
   logic              mem_req;
   logic [DATA_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data;
   logic              mem_valid;

   modport slave (
      input  addr, rn, clr, mem_data, mem_valid,
      output Inst, Read_ready, mem_req, mem_addr
   );

   modport master (
      output addr, rn, clr, mem_data, mem_valid,
      input  Inst, Read_ready, mem_req, mem_addr
   );

endinterface

// File: rtl/icache_array.sv
// Tag, valid and data storage for a direct-mapped cache.
// Latency: reads are combinational; writes land at the next clk edge.
// Backpressure: none; callers gate the write enables.
//
// Ports: clk, rst (clears valid bits only); idx selects the line for both read
// and write; rd_off -> rd_word, rd_tag, rd_valid; word_we writes wr_word at
// wr_off; tag_we writes wr_tag and sets valid; inv clears valid.
module icache_array
   import icache_pkg::*;
#(
   parameter int LINES      = DEF_LINES,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int TAG_W      = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [$clog2(LINES)-1:0]      idx,
   input  logic [$clog2(LINE_WORDS)-1:0] rd_off,
   output logic [TAG_W-1:0]              rd_tag,
   output logic                          rd_valid,
   output logic [DATA_W-1:0]             rd_word,
   input  logic                          word_we,
   input  logic [$clog2(LINE_WORDS)-1:0] wr_off,
   input  logic [DATA_W-1:0]             wr_word,
   input  logic                          tag_we,
   input  logic [TAG_W-1:0]              wr_tag,
   input  logic                          inv
);

   logic [LINES-1:0]  valid;
   logic [TAG_W-1:0]  tag_mem  [LINES];
   logic [DATA_W-1:0] data_mem [LINES][LINE_WORDS];

   assign rd_tag   = tag_mem[idx];
   assign rd_valid = valid[idx];
   assign rd_word  = data_mem[idx][rd_off];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid <= '0;
      end else if (tag_we) begin
         valid[idx] <= TRUE;
      end else if (inv) begin
         valid[idx] <= FALSE;
      end
   end

   // Payload storage is deliberately not reset; valid bits gate its use.
   always_ff @(posedge clk) begin
      if (word_we) data_mem[idx][wr_off] <= wr_word;
      if (tag_we)  tag_mem[idx]          <= wr_tag;
   end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache answering Fetcher reads, refilling lines word by word.
// Latency: hit 1 cycle after acceptance; miss responds 1 cycle after the last refill beat.
// Backpressure: rdy=0 freezes everything; requests are only taken in IDLE with Read_ready low.
//
// Ports: clk, rst (async, active-high), rdy (global freeze), bus (icache_if.slave):
// addr/rn/clr from the Fetcher and flow controller, Inst/Read_ready back,
// mem_req/mem_addr/mem_data/mem_valid to the memory controller.
module icache
   import icache_pkg::*;
#(
   parameter int LINES      = DEF_LINES,
   parameter int LINE_WORDS = DEF_LINE_WORDS,
   parameter int ADDR_USED  = DEF_ADDR_USED
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    rdy,
   icache_if.slave bus
);

   localparam int OFF_W  = $clog2(LINE_WORDS);
   localparam int IDX_W  = $clog2(LINES);
   localparam int IDX_LO = 2 + OFF_W;
   localparam int TAG_LO = IDX_LO + IDX_W;
   localparam int TAG_W  = ADDR_USED - TAG_LO;
   localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

   state_t            state;
   logic [DATA_W-1:0] req_addr;
   logic [DATA_W-1:0] inst_q;
   logic [DATA_W-1:0] mem_addr_q;
   logic              read_ready_q;
   logic              mem_req_q;
   logic              cancel;
   logic [OFF_W-1:0]  cnt;
   logic [OFF_W-1:0]  cnt_nxt;

   logic [IDX_W-1:0]  cur_idx;
   logic [OFF_W-1:0]  cur_off;
   logic [TAG_W-1:0]  arr_tag;
   logic              arr_valid;
   logic [DATA_W-1:0] arr_word;
   logic              accept, hit, last_beat, word_we, tag_we, inv;
   logic              unused_req_bits;

   // In IDLE the array is looked up with the live fetch address; otherwise
   // the latched request owns the line.
   assign cur_idx = (state == ST_IDLE) ? bus.addr[TAG_LO-1:IDX_LO] : req_addr[TAG_LO-1:IDX_LO];
   assign cur_off = (state == ST_IDLE) ? bus.addr[IDX_LO-1:2]      : req_addr[IDX_LO-1:2];

   // Read_ready low masks the edge where the Fetcher is still moving addr.
   assign accept    = (state == ST_IDLE) && bus.rn && !bus.clr && !read_ready_q;
   assign hit       = arr_valid && (arr_tag == bus.addr[ADDR_USED-1:TAG_LO]);
   assign last_beat = (cnt == LAST_WORD);
   assign cnt_nxt   = cnt + OFF_W'(1);
   assign word_we   = rdy && (state == ST_REFILL) && bus.mem_valid;
   assign tag_we    = word_we && last_beat;
   assign inv       = rdy && accept && !hit;

   assign unused_req_bits = ^{req_addr[DATA_W-1:ADDR_USED], req_addr[1:0]};

   icache_array #(
      .LINES      (LINES),
      .LINE_WORDS (LINE_WORDS),
      .TAG_W      (TAG_W)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .idx      (cur_idx),
      .rd_off   (cur_off),
      .rd_tag   (arr_tag),
      .rd_valid (arr_valid),
      .rd_word  (arr_word),
      .word_we  (word_we),
      .wr_off   (cnt),
      .wr_word  (bus.mem_data),
      .tag_we   (tag_we),
      .wr_tag   (req_addr[ADDR_USED-1:TAG_LO]),
      .inv      (inv)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= ST_IDLE;
         req_addr     <= '0;
         inst_q       <= '0;
         mem_addr_q   <= '0;
         read_ready_q <= FALSE;
         mem_req_q    <= FALSE;
         cancel       <= FALSE;
         cnt          <= '0;
      end else if (rdy) begin
         read_ready_q <= FALSE;
         case (state)
            ST_IDLE: begin
               cancel <= FALSE;
               if (accept) begin
                  req_addr <= bus.addr;
                  if (hit) begin
                     read_ready_q <= TRUE;
                     inst_q       <= arr_word;
                  end else begin
                     state      <= ST_REFILL;
                     mem_req_q  <= TRUE;
                     mem_addr_q <= line_base(bus.addr, LINE_WORDS);
                     cnt        <= '0;
                  end
               end
            end
            ST_REFILL: begin
               // A redirect cannot abort the refill; it only kills the response.
               if (bus.clr) cancel <= TRUE;
               if (bus.mem_valid) begin
                  cnt        <= cnt_nxt;
                  // Offset field tracks cnt, so the address wraps inside the line.
                  mem_addr_q <= {mem_addr_q[DATA_W-1:IDX_LO], cnt_nxt, 2'b00};
                  if (last_beat) begin
                     mem_req_q <= FALSE;
                     state     <= ST_RESPOND;
                  end
               end
            end
            ST_RESPOND: begin
               if (!cancel && !bus.clr) begin
                  read_ready_q <= TRUE;
                  inst_q       <= arr_word;
               end
               cancel <= FALSE;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.Inst       = inst_q;
   assign bus.Read_ready = read_ready_q;
   assign bus.mem_req    = mem_req_q;
   assign bus.mem_addr   = mem_addr_q;

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: misses, hits, conflicts, clr, rdy stall, async reset.
// Latency: checks 1-cycle hits and miss completion one cycle after the last beat.
// Backpressure: memory model answers each requested word after two idle cycles.
module tb_icache;

   logic clk = 1'b0;
   logic rst;
   logic rdy;

   icache_if bus();

   icache #(
      .LINES      (16),
      .LINE_WORDS (4),
      .ADDR_USED  (18)
   ) dut (
      .clk (clk),
      .rst (rst),
      .rdy (rdy),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          rr_rise  = 0;
   int          req_cycles = 0;
   logic        rr_prev  = 1'b0;
   int          gap;
   logic [31:0] beat_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Memory contents: line at 0x100 holds 0xA0..0xA3; other lines carry (addr[23:8]-1) in the top half.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      logic [15:0] hi;
      hi = a[23:8] - 16'd1;
      return {hi, 8'h00, 8'hA0 + {4'd0, a[5:2]}};
   endfunction

   function automatic logic [31:0] beat_at(input int i);
      if (i < beat_q.size()) return beat_q[i];
      return 32'hDEAD_BEEF;
   endfunction

   // Memory controller: two idle cycles, then one beat per requested word.
   initial begin
      gap           = 0;
      bus.mem_valid = 1'b0;
      bus.mem_data  = '0;
      forever begin
         @(negedge clk);
         bus.mem_valid = 1'b0;
         if (bus.mem_req && rdy && !rst) begin
            if (gap == 2) begin
               bus.mem_valid = 1'b1;
               bus.mem_data  = mem_word(bus.mem_addr);
               beat_q.push_back(bus.mem_addr);
               gap = 0;
            end else begin
               gap++;
            end
         end else begin
            gap = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (bus.Read_ready && !rr_prev) rr_rise++;
      rr_prev = bus.Read_ready;
      if (bus.mem_req) req_cycles++;
   end

   task automatic fetch(input logic [31:0] a, output int cyc, output logic [31:0] inst);
      @(negedge clk);
      bus.addr = a;
      bus.rn   = 1'b1;
      cyc      = 0;
      do begin
         @(negedge clk);
         cyc++;
      end while (!bus.Read_ready && cyc < 60);
      inst   = bus.Inst;
      bus.rn = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int          cyc;
      int          base;
      logic [31:0] inst;

      rst = 1'b1;
      rdy = 1'b1;
      bus.addr = '0;
      bus.rn   = 1'b0;
      bus.clr  = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_read_ready", {31'd0, bus.Read_ready}, 32'd0);
      check("rst_inst",       bus.Inst,                32'd0);
      check("rst_mem_req",    {31'd0, bus.mem_req},    32'd0);
      check("rst_mem_addr",   bus.mem_addr,            32'd0);
      rst = 1'b0;

      // Cold miss
      beat_q.delete();
      fetch(32'h100, cyc, inst);
      check("cold_latency", cyc, 14);
      check("cold_inst", inst, 32'h0000_00A0);
      check("cold_beats", beat_q.size(), 4);
      for (int i = 0; i < 4; i++) check("cold_beat_addr", beat_at(i), 32'h100 + 32'(4 * i));

      // Hit
      base = req_cycles;
      fetch(32'h108, cyc, inst);
      check("hit_latency", cyc, 1);
      check("hit_inst", inst, 32'h0000_00A2);
      check("hit_no_mem_req", req_cycles - base, 0);

      // Conflict: same index, different tag, then back again
      beat_q.delete();
      fetch(32'h1100, cyc, inst);
      check("conf1_latency", cyc, 14);
      check("conf1_inst", inst, 32'h0010_00A0);
      check("conf1_base", beat_at(0), 32'h1100);
      beat_q.delete();
      fetch(32'h100, cyc, inst);
      check("conf2_latency", cyc, 14);
      check("conf2_inst", inst, 32'h0000_00A0);
      check("conf2_base", beat_at(0), 32'h100);

      // rdy stall across a hit response
      @(negedge clk);
      base     = rr_rise;
      bus.addr = 32'h104;
      bus.rn   = 1'b1;
      @(negedge clk);
      check("stall_rr", {31'd0, bus.Read_ready}, 32'd1);
      check("stall_inst", bus.Inst, 32'h0000_00A1);
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check("stall_hold", {31'd0, bus.Read_ready}, 32'd1);
      end
      rdy    = 1'b1;
      bus.rn = 1'b0;
      @(negedge clk);
      check("stall_rr_drop", {31'd0, bus.Read_ready}, 32'd0);
      @(negedge clk);
      check("stall_pulses", rr_rise - base, 1);

      // clr and rn together: clr wins, request taken on the next edge
      bus.addr = 32'h108;
      bus.rn   = 1'b1;
      bus.clr  = 1'b1;
      @(negedge clk);
      check("clr_rn_blocked", {31'd0, bus.Read_ready}, 32'd0);
      bus.clr = 1'b0;
      @(negedge clk);
      check("clr_rn_next", {31'd0, bus.Read_ready}, 32'd1);
      check("clr_rn_inst", bus.Inst, 32'h0000_00A2);
      bus.rn = 1'b0;

      // clr in the middle of a refill
      @(negedge clk);
      beat_q.delete();
      base     = rr_rise;
      bus.addr = 32'h200;
      bus.rn   = 1'b1;
      for (int k = 0; k < 60 && beat_q.size() < 2; k++) @(negedge clk);
      @(negedge clk);
      bus.clr = 1'b1;
      bus.rn  = 1'b0;
      @(negedge clk);
      bus.clr = 1'b0;
      for (int k = 0; k < 60 && bus.mem_req; k++) @(negedge clk);
      repeat (3) @(negedge clk);
      check("clr_refill_no_rr", rr_rise - base, 0);
      check("clr_refill_beats", beat_q.size(), 4);
      fetch(32'h204, cyc, inst);
      check("clr_after_hit_latency", cyc, 1);
      check("clr_after_hit_inst", inst, 32'h0001_00A1);

      // Asynchronous reset during a refill
      @(negedge clk);
      beat_q.delete();
      bus.addr = 32'h300;
      bus.rn   = 1'b1;
      @(negedge clk);
      bus.rn = 1'b0;
      for (int k = 0; k < 60 && beat_q.size() < 1; k++) @(negedge clk);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("arst_mem_req", {31'd0, bus.mem_req}, 32'd0);
      check("arst_read_ready", {31'd0, bus.Read_ready}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      fetch(32'h300, cyc, inst);
      check("arst_refetch_latency", cyc, 14);
      check("arst_refetch_inst", inst, 32'h0002_00A0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
